// File: rtl/ga_pkg.sv
// ga_pkg: shared FSM state type, LFSR constants and helpers for the mutation engine.
// Used by ga_lfsr32 and mutation_engine.
package ga_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, COPY, MUTATE, WRITE, DONE} state_t;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] ZERO_SEED = 32'h1;
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? (v >> 1) ^ LFSR_MASK : v >> 1;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic mut_hit(input logic [31:0] v, input logic [7:0] rate);
    return v[7:0] < rate;
  endfunction
  // Scales the upper LFSR half into [0, n) without a divider.
  function automatic logic [31:0] gene_j(input logic [31:0] v, input int n);
    return ({16'b0, v[31:16]} * 32'(n)) >> 16;
  endfunction
endpackage

// File: rtl/ga_lfsr32.sv
// ga_lfsr32: 32-bit Galois LFSR with seed load and single-step advance.
// Ports: clk, rst_n (async active-low), load/seed (seed 0 becomes 1), step, value (current state).
module ga_lfsr32
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= ZERO_SEED;
    else if (load) value <= (seed == '0) ? ZERO_SEED : seed;
    else if (step) value <= lfsr_next(value);
endmodule

// File: rtl/mutation_engine.sv
// mutation_engine: copies each parent path N_COPIES times and applies LFSR-driven gene swaps.
// Ports: clk, rst_n (async active-low), start, rate, prg_seed, sel_population in;
//        mutant_pop, busy, done out. Optional MUTATION_ELITE_EN keeps copy 0 of every parent unmutated.
module mutation_engine
  import ga_pkg::*;
#(
  parameter int GENE_W    = 5,
  parameter int N_GENES   = 30,
  parameter int N_PARENTS = 10,
  parameter int N_COPIES  = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [7:0]                                    rate,
  input  logic [31:0]                                   prg_seed,
  input  logic [N_PARENTS*GENE_W*N_GENES-1:0]           sel_population,
  output logic [N_PARENTS*N_COPIES*GENE_W*N_GENES-1:0]  mutant_pop,
  output logic                                          busy,
  output logic                                          done
);
  localparam int PATH_W  = GENE_W * N_GENES;
  localparam int N_CHILD = N_PARENTS * N_COPIES;
  localparam int IW      = idx_w(N_GENES);
  localparam int PW      = idx_w(N_PARENTS);
  localparam int KW      = idx_w(N_COPIES);
  localparam int CW      = idx_w(N_CHILD);
  state_t                            r_state;
  logic [7:0]                        r_rate;
  logic [N_PARENTS*PATH_W-1:0]       r_parents;
  logic [N_CHILD*PATH_W-1:0]         r_pop;
  logic [PATH_W-1:0]                 r_path;
  logic [IW-1:0]                     r_i;
  logic [PW-1:0]                     r_par;
  logic [KW-1:0]                     r_copy;
  logic [CW-1:0]                     r_child;
  logic                              r_busy;
  logic                              r_done;
  logic [31:0]                       w_lfsr;
  logic [31:0]                       w_v;
  logic [IW-1:0]                     w_j;
  logic                              w_hit;
  ga_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state == LOAD),
    .step  (r_state == MUTATE),
    .seed  (prg_seed),
    .value (w_lfsr)
  );
  // The swap decision uses the value the LFSR is advancing to this cycle.
  assign w_v = lfsr_next(w_lfsr);
  assign w_j = IW'(gene_j(w_v, N_GENES));
`ifdef MUTATION_ELITE_EN
  assign w_hit = mut_hit(w_v, r_rate) && (r_copy != '0);
`else
  assign w_hit = mut_hit(w_v, r_rate);
`endif
  assign mutant_pop = r_pop;
  assign busy       = r_busy;
  assign done       = r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rate    <= '0;
      r_parents <= '0;
      r_pop     <= '0;
      r_path    <= '0;
      r_i       <= '0;
      r_par     <= '0;
      r_copy    <= '0;
      r_child   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= LOAD;
          r_busy  <= 1'b1;
        end
        LOAD: begin
          r_parents <= sel_population;
          r_rate    <= rate;
          r_child   <= '0;
          r_par     <= '0;
          r_copy    <= '0;
          r_state   <= COPY;
        end
        COPY: begin
          r_path  <= r_parents[r_par*PATH_W +: PATH_W];
          r_i     <= '0;
          r_state <= MUTATE;
        end
        MUTATE: begin
          // j == i writes the gene onto itself, so no special case is needed.
          if (w_hit) begin
            r_path[r_i*GENE_W +: GENE_W] <= r_path[w_j*GENE_W +: GENE_W];
            r_path[w_j*GENE_W +: GENE_W] <= r_path[r_i*GENE_W +: GENE_W];
          end
          r_i     <= r_i + 1'b1;
          r_state <= (r_i == IW'(N_GENES - 1)) ? WRITE : MUTATE;
        end
        WRITE: begin
          r_pop[r_child*PATH_W +: PATH_W] <= r_path;
          r_child <= r_child + 1'b1;
          r_copy  <= (r_copy == KW'(N_COPIES - 1)) ? '0 : r_copy + 1'b1;
          r_par   <= (r_copy == KW'(N_COPIES - 1)) ? r_par + 1'b1 : r_par;
          if (r_child == CW'(N_CHILD - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else r_state <= COPY;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mutation_engine.sv
// tb_mutation_engine: scoreboard bench for mutation_engine; expectations from a behavioural model.
module tb_mutation_engine;
  localparam int GW = 5, NG = 30, NP = 10, NK = 5;
  localparam int PW = GW * NG, NC = NP * NK;
  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0]        rate = '0;
  logic [31:0]       prg_seed = '0;
  logic [NP*PW-1:0]  par;
  logic [NC*PW-1:0]  pop;
  logic              busy, done;
  typedef struct {
    logic [NC*PW-1:0] pop;
    int               cyc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;

  mutation_engine #(.GENE_W(GW), .N_GENES(NG), .N_PARENTS(NP), .N_COPIES(NK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rate(rate), .prg_seed(prg_seed),
    .sel_population(par), .mutant_pop(pop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NC*PW-1:0] model(input logic [7:0] r, input logic [31:0] s);
    logic [NC*PW-1:0] out;
    logic [31:0]      v;
    logic [GW-1:0]    g[NG];
    logic [GW-1:0]    t;
    int               j;
    bit               elite;
    elite = 1'b0;
`ifdef MUTATION_ELITE_EN
    elite = 1'b1;
`endif
    v   = (s == 0) ? 32'h1 : s;
    out = '0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NK; k++) begin
        for (int i = 0; i < NG; i++) g[i] = par[p*PW + i*GW +: GW];
        for (int i = 0; i < NG; i++) begin
          v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
          j = (int'(v[31:16]) * NG) >> 16;
          if (v[7:0] < r && !(elite && k == 0)) begin
            t = g[i]; g[i] = g[j]; g[j] = t;
          end
        end
        for (int i = 0; i < NG; i++) out[(p*NK + k)*PW + i*GW +: GW] = g[i];
      end
    return out;
  endfunction

  initial begin
    exp_t e;
    int   h[32];
    int   bad;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk(cyc == e.cyc, "done_cycle", cyc, e.cyc);
          for (int c = 0; c < NC; c++)
            chk(pop[c*PW +: PW] == e.pop[c*PW +: PW], $sformatf("child%0d", c), pop[c*PW +: PW], e.pop[c*PW +: PW]);
          bad = 0;
          for (int c = 0; c < NC; c++) begin
            for (int g = 0; g < 32; g++) h[g] = 0;
            for (int i = 0; i < NG; i++) begin
              h[pop[c*PW + i*GW +: GW]]++;
              h[par[(c/NK)*PW + i*GW +: GW]]--;
            end
            for (int g = 0; g < 32; g++) if (h[g] != 0) bad++;
          end
          chk(bad == 0, "permutation", bad, 0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk(1'b0, "timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled by the following rising edge.
  task automatic go(input logic [7:0] r, input logic [31:0] s, input int hold);
    exp_t e;
    rate     = r;
    prg_seed = s;
    e.pop    = model(r, s);
    e.cyc    = cyc + 1602;
    sb.push_back(e);
    if (hold > 1602) begin
      e.cyc = cyc + 3205;
      sb.push_back(e);
    end
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int b0, d0;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NG; i++) par[p*PW + i*GW +: GW] = GW'((i*7 + p*3) % NG);
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(done == 1'b0, "reset_done", done, 0);
    chk(pop == '0, "reset_pop", pop[PW-1:0], 0);
    rst_n = 1'b1;
    go(8'd0, 32'h1234, 1);
    go(8'd255, 32'hACE1, 1);
    b0 = busy_cnt;
    d0 = done_cnt;
    go(8'd200, 32'h5A5A, 3000);
    chk(done_cnt - d0 == 2, "held_done_count", done_cnt - d0, 2);
    chk(busy_cnt - b0 == 3202, "held_busy_cycles", busy_cnt - b0, 3202);
    rate     = 8'd255;
    prg_seed = 32'hACE1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk(busy == 1'b0, "abort_busy", busy, 0);
    chk(done == 1'b0, "abort_done", done, 0);
    chk(pop == '0, "abort_pop", pop[PW-1:0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(8'd255, 32'hACE1, 1);
    go(8'd128, 32'h0, 1);
    go(8'd128, 32'h1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
